uint16_bcd_display: RTL and testbench

//  Sequential UInt16 -> 5-digit BCD converter using shift-add-3 (double dabble), one bit per cycle.

---
 rtl/uint16_bcd_display_pkg.sv | 35 +++
 rtl/uint16_bcd_display_add3.sv | 23 ++
 rtl/uint16_bcd_display.sv | 121 ++++++++++++
 tb/tb_uint16_bcd_display.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uint16_bcd_display_pkg.sv
// ----------------------------------------------------------------------------
// uint16_bcd_display_pkg : shared BCD types, display codes and blanking helper
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uint16_bcd_display_pkg;

  typedef logic [3:0]  BcdDigit;
  typedef logic [19:0] BcdDigits5;

  localparam BcdDigit BCD_BLANK = 4'hF;
  localparam BcdDigit BCD_ERROR = 4'hE;

  localparam BcdDigits5 BCD_ERR_PATTERN = {BCD_BLANK, BCD_BLANK, BCD_BLANK, BCD_BLANK, BCD_ERROR};

  // Digit0 is never blanked so that a zero result still shows a single 0.
  function automatic BcdDigits5 blank_leading(input BcdDigits5 d);
    BcdDigits5 r;
    logic      lead;
    r    = d;
    lead = 1'b1;
    for (int i = 4; i >= 1; i--) begin
      if (lead && (d[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uint16_bcd_display_add3.sv
// ----------------------------------------------------------------------------
// uint16_bcd_display_add3 : double-dabble digit correction (>=5 -> +3)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uint16_bcd_display_add3
  import uint16_bcd_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uint16_bcd_display.sv
// ----------------------------------------------------------------------------
// uint16_bcd_display : sequential UInt16 -> 5-digit BCD, one bit per cycle.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uint16_bcd_display
  import uint16_bcd_display_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] value_i,
  input  logic        invalid_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [19:0] digits_o
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t    state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  BcdDigits5 acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  BcdDigits5 digits_q, digits_d;
  logic      error_q, error_d;
  logic      done_q, done_d;

  BcdDigits5 adj;
  BcdDigits5 shifted;
  BcdDigits5 final_val;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    uint16_bcd_display_add3 u_add3 (
      .digit_i (acc_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  assign shifted = {adj[18:0], shreg_q[15]};

`ifdef LEADING_ZERO_BLANK_EN
  assign final_val = blank_leading(shifted);
`else
  assign final_val = shifted;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    error_d  = error_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (invalid_i) begin
            digits_d = BCD_ERR_PATTERN;
            error_d  = 1'b1;
            done_d   = 1'b1;
          end else begin
            shreg_d = value_i;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CONVERT;
          end
        end
      end
      CONVERT: begin
        acc_d   = shifted;
        shreg_d = {shreg_q[14:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        // cnt_q==15 means this edge shifts in the last of the 16 bits
        if (cnt_q == 4'd15) begin
          digits_d = final_val;
          error_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = (state_q == CONVERT);
  assign done_o   = done_q;
  assign error_o  = error_q;
  assign digits_o = digits_q;

endmodule

`default_nettype wire

// File: tb/tb_uint16_bcd_display.sv
// ----------------------------------------------------------------------------
// tb_uint16_bcd_display : directed self-checking bench for uint16_bcd_display
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uint16_bcd_display;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [15:0] value_i;
  logic        invalid_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [19:0] digits_o;

  int n_vec;
  int n_err;

  uint16_bcd_display #(.DIGITS(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .value_i   (value_i),
    .invalid_i (invalid_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .error_o   (error_o),
    .digits_o  (digits_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one start pulse; on return the start edge has passed.
  task automatic kick(input logic [15:0] v, input logic inv);
    start_i   = 1'b1;
    value_i   = v;
    invalid_i = inv;
    tick();
    start_i   = 1'b0;
    value_i   = 16'hDEAD;
    invalid_i = 1'b0;
  endtask

  // Counts cycles until done; busy-cycle count accumulated alongside.
  task automatic wait_done(input string tag, output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = 0;
    while (!done_o && cyc < 40) begin
      if (busy_o) bcyc++;
      tick();
      cyc++;
    end
    if (!done_o) chk({tag, "_timeout"}, 20'd0, 20'd1);
  endtask

  task automatic conv(input string tag, input logic [15:0] v,
                      input logic [19:0] exp_plain, input logic [19:0] exp_blank);
    int cyc, bcyc;
    kick(v, 1'b0);
    wait_done(tag, cyc, bcyc);
    chk({tag, "_lat"}, 20'(cyc), 20'd16);
    chk({tag, "_busy"}, 20'(bcyc), 20'd16);
    chk({tag, "_dig"}, digits_o, BLANK ? exp_blank : exp_plain);
    chk({tag, "_err"}, 20'(error_o), 20'd0);
    chk({tag, "_busy_end"}, 20'(busy_o), 20'd0);
    tick();
    chk({tag, "_done_1cyc"}, 20'(done_o), 20'd0);
    chk({tag, "_hold"}, digits_o, BLANK ? exp_blank : exp_plain);
  endtask

  initial begin
    int cyc, bcyc, pulses;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    value_i   = 16'd0;
    invalid_i = 1'b0;
    tick();
    tick();
    chk("rst_busy", 20'(busy_o), 20'd0);
    chk("rst_done", 20'(done_o), 20'd0);
    chk("rst_err", 20'(error_o), 20'd0);
    chk("rst_dig", digits_o, 20'd0);
    rst_n = 1'b1;
    tick();

    conv("zero", 16'd0, 20'h00000, 20'hFFFF0);
    conv("max", 16'd65535, 20'h65535, 20'h65535);
    conv("v10", 16'd10, 20'h00010, 20'hFFF10);
    conv("v1000", 16'd1000, 20'h01000, 20'hF1000);

    // Back-to-back: second start presented in the done cycle.
    kick(16'd1234, 1'b0);
    wait_done("b2b_a", cyc, bcyc);
    chk("b2b_a_dig", digits_o, BLANK ? 20'hF1234 : 20'h01234);
    kick(16'd9, 1'b0);
    wait_done("b2b_b", cyc, bcyc);
    chk("b2b_b_lat", 20'(cyc), 20'd16);
    chk("b2b_b_dig", digits_o, BLANK ? 20'hFFFF9 : 20'h00009);
    tick();

    // Invalid request shows the error pattern after one edge.
    kick(16'd777, 1'b1);
    chk("inv_done", 20'(done_o), 20'd1);
    chk("inv_dig", digits_o, 20'hFFFFE);
    chk("inv_err", 20'(error_o), 20'd1);
    chk("inv_busy", 20'(busy_o), 20'd0);
    tick();
    chk("inv_done_drop", 20'(done_o), 20'd0);
    chk("inv_hold", digits_o, 20'hFFFFE);
    conv("after_inv", 16'd42, 20'h00042, 20'hFFF42);

    // Start during CONVERT must be ignored.
    kick(16'd500, 1'b0);
    repeat (4) tick();
    start_i   = 1'b1;
    value_i   = 16'd1;
    invalid_i = 1'b1;
    tick();
    start_i   = 1'b0;
    invalid_i = 1'b0;
    wait_done("ign", cyc, bcyc);
    chk("ign_lat", 20'(cyc + 5), 20'd16);
    chk("ign_dig", digits_o, BLANK ? 20'hFF500 : 20'h00500);
    chk("ign_err", 20'(error_o), 20'd0);
    tick();
    chk("ign_no_extra", 20'(done_o | busy_o), 20'd0);

    // Reset in the middle of a conversion aborts it silently.
    kick(16'd4321, 1'b0);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", 20'(busy_o), 20'd0);
    chk("mid_rst_done", 20'(done_o), 20'd0);
    chk("mid_rst_err", 20'(error_o), 20'd0);
    chk("mid_rst_dig", digits_o, 20'd0);
    pulses = 0;
    repeat (20) begin
      tick();
      if (done_o) pulses++;
    end
    chk("mid_rst_no_done", 20'(pulses), 20'd0);
    conv("post_rst", 16'd4321, 20'h04321, 20'hF4321);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
